instr_deser: RTL and testbench
==============================

# instr_deser

Serial-to-parallel instruction front end between the xtal CPU's SPI-style link and the request queue. It shifts in one fixed-width instruction per chip-select frame and checks the frame length. It holds the decoded opcode/key_addr/text_addr in a single-entry output register and presents it to the request queue with a valid/ready handshake. It flags malformed frames and frames lost because the output register was still occupied.

## Interface
- ADDRW, 8, width of key_addr and text_addr
- OPCODEW, 2, width of opcode; INSTRW = 2*ADDRW + OPCODEW (18 at defaults)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sclk  in  1  serial clock from CPU, asynchronous to clk; data sampled on its rising edge
- cs_n  in  1  frame select from CPU, active-low, asynchronous
- mosi  in  1  serial data from CPU, MSB first
- ready_in  in  1  queue can accept (request queue's ready_out)
- opcode  out  OPCODEW  decoded opcode; reset 0
- key_addr  out  ADDRW  decoded key address; reset 0
- text_addr  out  ADDRW  decoded text address; reset 0
- valid_out  out  1  instruction held and offered to queue (queue's valid_in); reset 0
- busy  out  1  equals valid_out, status to CPU; reset 0
- err_frame  out  1  one-cycle pulse: frame closed with bit count != INSTRW; reset 0
- err_overflow  out  1  one-cycle pulse: good frame dropped because output register full; reset 0

## Operation
- sclk, cs_n, mosi each pass through a 2-flop synchroniser, plus one history flop for edge detection.
  - Sclk rise event: synced sclk is 1 and history is 0. Mosi is taken from its synchronised copy in the same cycle.
- FSM with states IDLE and SHIFT.
  - IDLE: leave on a cs_n fall event (synced 0, history 1). Clear shift register and bit_cnt, go to SHIFT.
  - SHIFT, on each sclk rise: shift register <= {shreg[INSTRW-2:0], mosi}. bit_cnt increments, saturating at INSTRW+1 (marks "too long").
  - SHIFT, on a cs_n rise event: go to IDLE and evaluate the frame.
- Frame evaluation at the cs_n rise event:
  - bit_cnt != INSTRW: pulse err_frame and discard the frame.
  - bit_cnt == INSTRW and the output slot is free: load the slot. The slot is free when valid_out == 0, or when valid_out && ready_in in this same cycle.
  - Loaded fields: opcode <= shreg[INSTRW-1 -: OPCODEW], key_addr <= shreg[2*ADDRW-1 -: ADDRW], text_addr <= shreg[ADDRW-1:0]. valid_out <= 1.
  - bit_cnt == INSTRW and the slot is occupied with no handshake this cycle: pulse err_overflow, discard the frame, leave the held instruction unchanged.
- Handshake: when valid_out && ready_in, valid_out clears next cycle, unless a new frame loads in the same cycle, in which case it stays 1 with the new fields.
- Held outputs are stable while valid_out == 1 and ready_in == 0.
- Sclk edges while in IDLE (cs_n high) are ignored.
- Reset mid-frame: everything returns to reset values and the FSM enters IDLE. A frame already in progress (cs_n low at reset release) is ignored until cs_n goes high and falls again.

## Timing
- CPU timing requirement: sclk high and low phases ≥ 3 clk periods each; cs_n setup/hold around first and last sclk edge ≥ 3 clk periods.
- Pin-to-event latency is 2–3 clk cycles (synchroniser).
- Cs_n rise event in cycle N:
  - valid_out and the output fields are updated at the clk edge ending cycle N, and are visible in cycle N+1.
  - err_frame or err_overflow is high for exactly cycle N+1.
- Throughput: one instruction per frame. Back-to-back frames are accepted when the queue keeps ready_in high.
- valid_out does not depend combinationally on ready_in. All outputs are registered.

## Test plan
- Single frame, ready_in=1: 18 bits 01_10100101_00111100 -> within 4 clk of cs_n rise, opcode=1, key_addr=0xA5, text_addr=0x3C, valid_out=1 for 1 cycle; no error pulses.
- Backpressure: ready_in=0 while sending 01_A5_3C -> valid_out stays 1, fields stable. A second good frame 10_11_22 -> err_overflow pulses once and held fields stay 01_A5_3C. Raising ready_in -> valid_out drops next cycle.
- Short/long frame: 17 bits, then separately 19 bits -> err_frame pulses once each; valid_out stays 0.
- Simultaneous: hold 01_A5_3C with ready_in=0. Raise ready_in in exactly the cycle of the next frame's cs_n rise event (frame 11_FF_00) -> no err_overflow; valid_out stays 1 with fields 3/0xFF/0x00.
- Sclk toggling with cs_n high (5 edges), then a normal frame 00_01_02 -> decoded exactly 0/0x01/0x02.
- rst_n pulsed low after 9 bits of a frame -> all outputs 0. Finishing that frame yields no valid_out and no errors. The next full frame 10_5A_C3 decodes correctly.

Source files
------------

// File: rtl/instr_deser.sv
// Serial-to-parallel instruction front end: one fixed-width instruction per
// chip-select frame, held in a single output slot offered to the request queue.
module instr_deser #(
    parameter int ADDRW   = 8,
    parameter int OPCODEW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sclk,
    input  logic               cs_n,
    input  logic               mosi,
    input  logic               ready_in,
    output logic [OPCODEW-1:0] opcode,
    output logic [ADDRW-1:0]   key_addr,
    output logic [ADDRW-1:0]   text_addr,
    output logic               valid_out,
    output logic               busy,
    output logic               err_frame,
    output logic               err_overflow
);

    localparam int INSTRW = 2 * ADDRW + OPCODEW;
    localparam int CNTW   = $clog2(INSTRW + 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic [INSTRW-1:0] shreg;
    logic [CNTW-1:0]   bit_cnt;

    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_hist;
    logic       cs_hist;

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;
    logic mosi_bit;
    logic slot_free;

    // cs_n copies reset low so a frame already open at reset release never
    // produces a fall event; it must close and reopen first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b00;
            mosi_sync <= 2'b00;
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            cs_sync   <= {cs_sync[0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_hist <= sclk_sync[1];
            cs_hist   <= cs_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_hist;
    assign cs_fall   = ~cs_sync[1] & cs_hist;
    assign cs_rise   = cs_sync[1] & ~cs_hist;
    assign mosi_bit  = mosi_sync[1];

    // Handshake: the slot transfers on any cycle where valid_out && ready_in;
    // valid_out never depends on ready_in combinationally, and the held
    // fields stay frozen while valid_out is high and ready_in is low.
    assign slot_free = ~valid_out | ready_in;
    assign busy      = valid_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            opcode       <= '0;
            key_addr     <= '0;
            text_addr    <= '0;
            valid_out    <= 1'b0;
            err_frame    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_frame    <= 1'b0;
            err_overflow <= 1'b0;
            if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        if (bit_cnt != CNTW'(INSTRW)) begin
                            err_frame <= 1'b1;
                        end else if (slot_free) begin
                            opcode    <= shreg[INSTRW-1 -: OPCODEW];
                            key_addr  <= shreg[2*ADDRW-1 -: ADDRW];
                            text_addr <= shreg[ADDRW-1:0];
                            valid_out <= 1'b1;
                        end else begin
                            err_overflow <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shreg <= {shreg[INSTRW-2:0], mosi_bit};
                        // Saturate one past full length so overlong frames stay distinguishable.
                        if (bit_cnt != CNTW'(INSTRW + 1)) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_deser.sv
// Directed and randomized checks of instr_deser against a frame-level
// reference model and an in-order scoreboard of accepted instructions.
module tb_instr_deser;

    localparam int ADDRW   = 8;
    localparam int OPCODEW = 2;
    localparam int INSTRW  = 2 * ADDRW + OPCODEW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic ready_in = 1'b0;

    logic [OPCODEW-1:0] opcode;
    logic [ADDRW-1:0]   key_addr;
    logic [ADDRW-1:0]   text_addr;
    logic               valid_out;
    logic               busy;
    logic               err_frame;
    logic               err_overflow;

    int n_asserts = 0;
    int n_fails   = 0;
    int n_ferr    = 0;
    int n_ovf     = 0;

    logic [INSTRW-1:0] exp_q[$];
    logic [INSTRW-1:0] got_q[$];
    logic              model_held;

    instr_deser #(.ADDRW(ADDRW), .OPCODEW(OPCODEW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .ready_in    (ready_in),
        .opcode      (opcode),
        .key_addr    (key_addr),
        .text_addr   (text_addr),
        .valid_out   (valid_out),
        .busy        (busy),
        .err_frame   (err_frame),
        .err_overflow(err_overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    function automatic logic [INSTRW-1:0] pack(input logic [1:0] op, input logic [7:0] k,
                                               input logic [7:0] t);
        return {op, k, t};
    endfunction

    function automatic logic [INSTRW-1:0] held_fields();
        return {opcode, key_addr, text_addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cs_low();
        cs_n = 1'b0;
        ticks(4);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        ticks(4);
        sclk = 1'b1;
        ticks(4);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] val, input int nbits);
        cs_low();
        for (int i = nbits - 1; i >= 0; i--) send_bit(val[i]);
        ticks(4);
        cs_n = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int max_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick();
            if (valid_out) lat = i;
        end
        check(tag, (lat != 0 && lat <= max_lat) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // ---------------- monitor: error pulses, handshakes, stability ----------------
    logic [INSTRW-1:0] prev_fields;
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic              prev_rst = 1'b0;

    always @(negedge clk) begin
        if (err_frame) n_ferr++;
        if (err_overflow) n_ovf++;
        if (valid_out && ready_in) got_q.push_back(held_fields());
        n_asserts++;
        assert (busy === valid_out) else begin
            n_fails++;
            $error("FAIL busy_eq_valid: observed %0b expected %0b", busy, valid_out);
        end
        if (prev_rst && rst_n && prev_valid && !prev_ready) begin
            n_asserts++;
            assert ({valid_out, held_fields()} === {1'b1, prev_fields}) else begin
                n_fails++;
                $error("FAIL hold_stable: observed %0h expected %0h",
                       {valid_out, held_fields()}, {1'b1, prev_fields});
            end
        end
        prev_fields = held_fields();
        prev_valid  = valid_out;
        prev_ready  = ready_in;
        prev_rst    = rst_n;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [INSTRW-1:0] fa, fb, fc, fd, fe;
        int f0, o0;
        fa = pack(2'd1, 8'hA5, 8'h3C);
        fb = pack(2'd2, 8'h11, 8'h22);
        fc = pack(2'd3, 8'hFF, 8'h00);
        fd = pack(2'd0, 8'h01, 8'h02);
        fe = pack(2'd2, 8'h5A, 8'hC3);

        ticks(3);
        check("reset_outputs", {29'd0, valid_out, err_frame, err_overflow} | 32'(held_fields()), 32'd0);
        rst_n = 1'b1;
        ticks(3);

        // Single frame, queue ready
        ready_in = 1'b1;
        f0 = n_ferr; o0 = n_ovf;
        send_frame(32'(fa), INSTRW);
        wait_valid("t1_latency", 4);
        check("t1_fields", 32'(held_fields()), 32'(fa));
        exp_q.push_back(fa);
        tick();
        check("t1_valid_one_cycle", 32'(valid_out), 32'd0);
        ticks(6);
        check("t1_no_errors", 32'((n_ferr - f0) + (n_ovf - o0)), 32'd0);

        // Backpressure and overflow
        ready_in = 1'b0;
        send_frame(32'(fa), INSTRW);
        ticks(8);
        check("t2_held_valid", 32'(valid_out), 32'd1);
        check("t2_held_fields", 32'(held_fields()), 32'(fa));
        exp_q.push_back(fa);
        o0 = n_ovf;
        send_frame(32'(fb), INSTRW);
        ticks(8);
        check("t2_overflow_pulse", 32'(n_ovf - o0), 32'd1);
        check("t2_fields_kept", 32'(held_fields()), 32'(fa));
        ready_in = 1'b1;
        tick();
        check("t2_drop_after_ready", 32'(valid_out), 32'd0);

        // Short and long frames
        f0 = n_ferr;
        send_frame(32'h1_5A5A, INSTRW - 1);
        ticks(8);
        check("t3_short_err", 32'(n_ferr - f0), 32'd1);
        check("t3_short_novalid", 32'(valid_out), 32'd0);
        f0 = n_ferr;
        send_frame(32'h5_A5A5, INSTRW + 1);
        ticks(8);
        check("t3_long_err", 32'(n_ferr - f0), 32'd1);
        check("t3_long_novalid", 32'(valid_out), 32'd0);

        // Ready raised exactly in the cycle of the cs_n rise event
        ready_in = 1'b0;
        send_frame(32'(fa), INSTRW);
        ticks(8);
        exp_q.push_back(fa);
        o0 = n_ovf;
        cs_low();
        for (int i = INSTRW - 1; i >= 0; i--) send_bit(fc[i]);
        ticks(4);
        cs_n = 1'b1;
        ticks(2);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("t4_valid_kept", 32'(valid_out), 32'd1);
        check("t4_new_fields", 32'(held_fields()), 32'(fc));
        exp_q.push_back(fc);
        ticks(8);
        check("t4_no_overflow", 32'(n_ovf - o0), 32'd0);

        // Sclk activity with cs_n high is ignored
        ready_in = 1'b1;
        ticks(4);
        ready_in = 1'b0;
        repeat (5) begin
            mosi = 1'($urandom_range(0, 1));
            sclk = 1'b1;
            ticks(4);
            sclk = 1'b0;
            ticks(4);
        end
        f0 = n_ferr; o0 = n_ovf;
        send_frame(32'(fd), INSTRW);
        ticks(8);
        check("t5_fields", {31'd0, valid_out} << 20 | 32'(held_fields()), (32'd1 << 20) | 32'(fd));
        check("t5_no_errors", 32'((n_ferr - f0) + (n_ovf - o0)), 32'd0);
        exp_q.push_back(fd);
        ready_in = 1'b1;
        ticks(4);

        // Reset in the middle of a frame while an instruction is held
        ready_in = 1'b0;
        send_frame(32'(pack(2'd1, 8'h77, 8'h88)), INSTRW);
        ticks(8);
        cs_low();
        for (int i = INSTRW - 1; i >= INSTRW - 9; i--) send_bit(fe[i]);
        rst_n = 1'b0;
        #2;
        check("t6_reset_outputs",
              {29'd0, valid_out, err_frame, err_overflow} | 32'(held_fields()), 32'd0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        f0 = n_ferr; o0 = n_ovf;
        for (int i = INSTRW - 10; i >= 0; i--) send_bit(fe[i]);
        ticks(4);
        cs_n = 1'b1;
        ticks(8);
        check("t6_abandoned_novalid", 32'(valid_out), 32'd0);
        check("t6_abandoned_noerr", 32'((n_ferr - f0) + (n_ovf - o0)), 32'd0);
        ready_in = 1'b1;
        send_frame(32'(fe), INSTRW);
        wait_valid("t6_next_latency", 4);
        check("t6_next_fields", 32'(held_fields()), 32'(fe));
        exp_q.push_back(fe);
        ticks(4);

        // Randomized frames against the frame-level model
        model_held = 1'b0;
        for (int f = 0; f < 16; f++) begin
            logic [31:0] data;
            logic        rdy;
            int          len;
            logic        exp_fe, exp_ov;
            rdy  = 1'($urandom_range(0, 1));
            len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 21)) : INSTRW;
            data = $urandom;
            ready_in = rdy;
            if (rdy) model_held = 1'b0;
            ticks(3);
            f0 = n_ferr; o0 = n_ovf;
            send_frame(data, len);
            ticks(8);
            exp_fe = (len != INSTRW);
            exp_ov = (len == INSTRW) && model_held && !rdy;
            if (len == INSTRW && !exp_ov) begin
                exp_q.push_back(data[INSTRW-1:0]);
                model_held = !rdy;
            end
            check("rnd_err_frame", 32'(n_ferr - f0), 32'(exp_fe));
            check("rnd_err_overflow", 32'(n_ovf - o0), 32'(exp_ov));
            check("rnd_valid", 32'(valid_out), 32'(model_held));
        end

        // Drain and compare accepted instructions in order
        ready_in = 1'b1;
        ticks(6);
        check("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check("sb_item", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
